// File: rtl/instr_sequencer_pkg.sv
// Shared processor package: opcode encodings, sequencer state enum and
// opcode-class helpers. The sequencer and the control decoder both import it.
package instr_sequencer_pkg;

  localparam int unsigned PcWidth = 10;
  localparam int unsigned OpWidth = 5;

  typedef logic [PcWidth-1:0] pc_t;
  typedef logic [OpWidth-1:0] opcode_t;

  localparam opcode_t OpNop      = 5'b00000;
  localparam opcode_t OpBLookup  = 5'b00001;
  localparam opcode_t OpB        = 5'b00010;
  localparam opcode_t OpBeq      = 5'b00011;
  localparam opcode_t OpLoadByte = 5'b10000;
  localparam opcode_t OpLoad1    = 5'b10110;
  localparam opcode_t OpLoad2    = 5'b11010;
  localparam opcode_t OpLoad3    = 5'b11011;
  localparam opcode_t OpSwap     = 5'b11111;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StMemWait,
    StSwap2,
    StDone
  } seq_state_e;

  function automatic logic is_load(opcode_t op);
    return (op == OpLoadByte) || (op == OpLoad1) || (op == OpLoad2) || (op == OpLoad3);
  endfunction

  function automatic logic is_swap(opcode_t op);
    return op == OpSwap;
  endfunction

  function automatic logic branch_taken(opcode_t op, logic cond);
    return (op == OpB) || (op == OpBLookup) || ((op == OpBeq) && cond);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer bus: instruction-side inputs (start, opcode, branch_cond, target,
// halt_addr) and control outputs (pc, commit, swap_phase, busy, done).
// slave  : the sequencer itself.
// master : the surrounding datapath / environment.
interface instr_sequencer_if;
  import instr_sequencer_pkg::*;

  logic    start;
  opcode_t opcode;
  logic    branch_cond;
  pc_t     target;
  pc_t     halt_addr;
  pc_t     pc;
  logic    commit;
  logic    swap_phase;
  logic    busy;
  logic    done;

  modport slave (
    input  start, opcode, branch_cond, target, halt_addr,
    output pc, commit, swap_phase, busy, done
  );

  modport master (
    output start, opcode, branch_cond, target, halt_addr,
    input  pc, commit, swap_phase, busy, done
  );

endinterface

// File: rtl/pc_next.sv
// Combinational next-pc: target for B / B_LOOKUP / taken BEQ, else pc+1
// (wraps naturally at the top of the address space).
// Ports: pc, opcode, branch_cond, target in; next_pc out.
module pc_next
  import instr_sequencer_pkg::*;
(
  input  pc_t     pc,
  input  opcode_t opcode,
  input  logic    branch_cond,
  input  pc_t     target,
  output pc_t     next_pc
);

  always_comb begin
    next_pc = pc + pc_t'(1);
    if (branch_taken(opcode, branch_cond)) begin
      next_pc = target;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer. Steps pc through the program, stretching
// loads (EXEC + MEMWAIT) and swaps (EXEC + SWAP2), and stops in DONE after the
// instruction at halt_addr commits.
// Ports: clk, reset (synchronous, active-high), bus (instr_sequencer_if.slave).
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.slave  bus
);

  seq_state_e state_q;
  pc_t        pc_q;
  logic       busy_q;
  logic       done_q;
  logic       swap_phase_q;

  pc_t  next_pc;
  logic final_cycle;
  logic commit;

  pc_next u_pc_next (
    .pc          (pc_q),
    .opcode      (bus.opcode),
    .branch_cond (bus.branch_cond),
    .target      (bus.target),
    .next_pc     (next_pc)
  );

  // commit depends on the opcode fetched at the current pc, so it cannot be
  // registered: a load's first cycle must not commit.
  always_comb begin
    final_cycle = 1'b0;
    commit      = 1'b0;
    case (state_q)
      StExec: begin
        final_cycle = !is_load(bus.opcode) && !is_swap(bus.opcode);
        commit      = !is_load(bus.opcode);
      end
      StMemWait, StSwap2: begin
        final_cycle = 1'b1;
        commit      = 1'b1;
      end
      default: begin
        final_cycle = 1'b0;
        commit      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      swap_phase_q <= 1'b0;
    end else if (final_cycle) begin
      swap_phase_q <= 1'b0;
      // Halt wins over any branch: pc stays on the halting instruction.
      if (pc_q == bus.halt_addr) begin
        state_q <= StDone;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end else begin
        state_q <= StExec;
        pc_q    <= next_pc;
      end
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_q <= StExec;
            pc_q    <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StExec: begin
          // Only multi-cycle opcodes reach here.
          if (is_load(bus.opcode)) begin
            state_q <= StMemWait;
          end else begin
            state_q      <= StSwap2;
            swap_phase_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= StIdle;
          pc_q         <= '0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          swap_phase_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc         = pc_q;
  assign bus.commit     = commit;
  assign bus.swap_phase = swap_phase_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  one-cycle request to run the program from address 0.
REQ-004 SHALL have port: opcode  input  5  opcode of the instruction at pc.
REQ-005 SHALL have port: branch_cond  input  1  ALU branch condition for the current instruction.
REQ-006 SHALL have port: target  input  10  branch target, already muxed between immediate and lookup table.
REQ-007 SHALL have port: halt_addr  input  10  address of the final program instruction; sampled every cycle.
REQ-008 SHALL have port: pc  output  10  program counter addressing instruction memory.
REQ-009 SHALL have port: commit  output  1  qualifier ANDed with RegWrite/MemWrite; writes are effective only when 1.
REQ-010 SHALL have port: swap_phase  output  1  0 = first swap write, 1 = second swap write.
REQ-011 SHALL have port: busy  output  1  high while a program is executing.
REQ-012 SHALL have port: done  output  1  high from program completion until the next start or reset.

Function
REQ-013 SHALL implement states IDLE, EXEC, MEMWAIT, SWAP2, DONE.
REQ-014 In IDLE: pc=0, busy=0, commit=0, done=0; start=1 -> EXEC next cycle with pc=0.
REQ-015 Single-cycle opcodes (every opcode not named in REQ-016/017): EXEC, commit=1 for exactly one cycle, then advance.
REQ-016 Loads (10000, 10110, 11010, 11011): EXEC cycle commit=0 -> MEMWAIT; MEMWAIT cycle commit=1, then advance; latency 2 cycles.
REQ-017 SWAP (11111): EXEC cycle commit=1, swap_phase=0 -> SWAP2; SWAP2 cycle commit=1, swap_phase=1, then advance.
REQ-018 swap_phase SHALL be 0 in every state except SWAP2.
REQ-019 Advance rule: next pc=target if opcode is B (00010) or B_LOOKUP (00001), or BEQ (00011) with branch_cond=1; otherwise pc+1.
REQ-020 branch_cond and target SHALL be sampled only in the instruction's final cycle.
REQ-021 pc+1 SHALL wrap 1023 -> 0 with no error indication.
REQ-022 NOP (00000) SHALL execute as a single-cycle opcode and issue commit=1; downstream write enables remain 0.
REQ-023 Halt: if pc==halt_addr in an instruction's final cycle, that instruction commits normally, then next state is DONE and pc is held; halt takes priority over a taken branch.
REQ-024 In DONE: done=1, busy=0, commit=0, pc held; start=1 -> EXEC with pc=0, done=0 next cycle.
REQ-025 busy SHALL be 1 in EXEC, MEMWAIT and SWAP2 and 0 otherwise.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 Undefined opcodes SHALL be treated as single-cycle.

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE with pc=0, commit=0, swap_phase=0, busy=0, done=0, regardless of state, including mid-load and mid-swap.
REQ-029 reset SHALL take priority over start in the same cycle.

Structure
REQ-030 Opcode constants and the state enum SHALL live in the shared processor package, which the control decoder also uses.
REQ-031 Next-pc computation SHALL be a combinational sub-module pc_next (inputs pc, opcode, branch_cond, target; output next pc); all state is held in instr_sequencer.

Verification
REQ-032 Run: start, halt_addr=3, four ADDs -> pc 0,1,2,3; commit=1 for 4 cycles; done=1 in cycle 5; pc held at 3.
REQ-033 Load: LOAD_BYTE at pc=0 -> commit 0 then 1; pc=1 only after MEMWAIT.
REQ-034 Swap: SWAP at pc=0 -> commit=1 for 2 cycles with swap_phase 0 then 1; next pc=1.
REQ-035 Branches: BEQ branch_cond=0 -> pc+1; branch_cond=1 with target=0x2A0 -> pc=0x2A0; B_LOOKUP with target=5 -> pc=5; pc=1023 non-branch -> pc=0.
REQ-036 Reset asserted in MEMWAIT and in SWAP2 -> next cycle IDLE, all outputs 0; start during busy ignored; start in DONE restarts at pc=0.
